// File: rtl/gtfwizard_0_gtwiz_rx_mode_drp_ctrl.sv
// Purpose: on each rising request, read-modify-write two RX phase-alignment DRP registers to their MM or AM values, then return a held done level.
// Latency: 13 drp_clk_in cycles from drp_reconfig_rdy_in rise to drp_reconfig_done_out rise when gnt/drdy respond without wait states.
// Backpressure: holds drp_req_out until drp_gnt_in and waits for drp_rdy_in; aborts with the sticky error flag after P_DRP_TIMEOUT cycles.
module gtfwizard_0_gtwiz_rx_mode_drp_ctrl #(
    parameter int unsigned P_DRP_TIMEOUT = 255,
    parameter int unsigned P_DONE_HOLD   = 8,
    parameter logic [9:0]  P_REG0_ADDR   = 10'h000,
    parameter logic [15:0] P_REG0_MASK   = 16'h0000,
    parameter logic [15:0] P_REG0_MM_VAL = 16'h0000,
    parameter logic [15:0] P_REG0_AM_VAL = 16'h0000,
    parameter logic [9:0]  P_REG1_ADDR   = 10'h000,
    parameter logic [15:0] P_REG1_MASK   = 16'h0000,
    parameter logic [15:0] P_REG1_MM_VAL = 16'h0000,
    parameter logic [15:0] P_REG1_AM_VAL = 16'h0000
) (
    input  logic        drp_clk_in,
    input  logic        drp_reset_in,
    input  logic        drp_reconfig_rdy_in,
    input  logic        drp_switch_am_in,
    output logic        drp_reconfig_done_out,
    output logic        drp_reconfig_error_out,
    output logic        drp_mode_am_out,
    output logic        drp_req_out,
    input  logic        drp_gnt_in,
    output logic        drp_en_out,
    output logic        drp_we_out,
    output logic [9:0]  drp_addr_out,
    output logic [15:0] drp_di_out,
    input  logic [15:0] drp_do_in,
    input  logic        drp_rdy_in,
    output logic [2:0]  sm_drp_ctrl_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD      = 3'd2,
        S_WAIT_RD = 3'd3,
        S_WR      = 3'd4,
        S_WAIT_WR = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Counts are compared one short of the limit so that a wait lasts exactly
    // P_DRP_TIMEOUT cycles and done stays high exactly P_DONE_HOLD cycles.
    localparam logic [7:0] TMO_LAST  = 8'(P_DRP_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(P_DONE_HOLD - 1);

    state_t      state, state_nxt;
    logic [2:0]  rdy_sync;
    logic [2:0]  am_sync;
    logic        rdy_s, rdy_s_d, am_s, start;
    logic [7:0]  cnt, cnt_nxt;
    logic        idx, idx_nxt;
    logic        mode_sel, mode_sel_nxt;
    logic        mode_am, mode_am_nxt;
    logic        err, err_nxt;
    logic [15:0] di_q, di_nxt;
    logic        tmo;
    logic [9:0]  reg_addr;
    logic [15:0] reg_mask, reg_val;

    // The request synchronizer resets high so a level held across reset reads
    // as "already seen" and cannot fake a rising edge.
    always_ff @(posedge drp_clk_in or posedge drp_reset_in) begin
        if (drp_reset_in) begin
            rdy_sync <= 3'b111;
            rdy_s_d  <= 1'b1;
            am_sync  <= 3'b000;
        end else begin
            rdy_sync <= {rdy_sync[1:0], drp_reconfig_rdy_in};
            rdy_s_d  <= rdy_sync[2];
            am_sync  <= {am_sync[1:0], drp_switch_am_in};
        end
    end

    assign rdy_s = rdy_sync[2];
    assign am_s  = am_sync[2];
    assign start = rdy_s & ~rdy_s_d;

    always_ff @(posedge drp_clk_in or posedge drp_reset_in) begin
        if (drp_reset_in) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            idx      <= 1'b0;
            mode_sel <= 1'b0;
            mode_am  <= 1'b0;
            err      <= 1'b0;
            di_q     <= 16'h0000;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            mode_sel <= mode_sel_nxt;
            mode_am  <= mode_am_nxt;
            err      <= err_nxt;
            di_q     <= di_nxt;
        end
    end

    assign reg_addr = idx ? P_REG1_ADDR : P_REG0_ADDR;
    assign reg_mask = idx ? P_REG1_MASK : P_REG0_MASK;
    assign reg_val  = idx ? (mode_sel ? P_REG1_AM_VAL : P_REG1_MM_VAL)
                          : (mode_sel ? P_REG0_AM_VAL : P_REG0_MM_VAL);
    assign tmo      = (cnt == TMO_LAST);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        mode_sel_nxt = mode_sel;
        mode_am_nxt  = mode_am;
        err_nxt      = err;
        di_nxt       = di_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_sel_nxt = am_s;
                    err_nxt      = 1'b0;
                    idx_nxt      = 1'b0;
                    cnt_nxt      = 8'd0;
                    state_nxt    = S_REQ;
                end
            end
            S_REQ, S_RD, S_WR: begin
                // Strobes only fire with gnt held, so RD/WR also wait on it.
                if (drp_gnt_in) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = (state == S_REQ) ? S_RD :
                                (state == S_RD)  ? S_WAIT_RD : S_WAIT_WR;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_WAIT_RD: begin
                if (drp_rdy_in) begin
                    di_nxt    = (drp_do_in & ~reg_mask) | (reg_val & reg_mask);
                    cnt_nxt   = 8'd0;
                    state_nxt = S_WR;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_WAIT_WR: begin
                if (drp_rdy_in) begin
                    cnt_nxt = 8'd0;
                    if (idx) begin
                        mode_am_nxt = mode_sel;
                        state_nxt   = S_DONE;
                    end else begin
                        idx_nxt   = 1'b1;
                        state_nxt = S_RD;
                    end
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_DONE: begin
                if ((cnt >= HOLD_LAST) && !rdy_s) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_IDLE;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so reset removes them asynchronously.
    assign drp_req_out            = (state == S_REQ) || (state == S_RD) || (state == S_WAIT_RD) ||
                                    (state == S_WR)  || (state == S_WAIT_WR);
    assign drp_en_out             = ((state == S_RD) || (state == S_WR)) && drp_gnt_in;
    assign drp_we_out             = (state == S_WR) && drp_gnt_in;
    assign drp_addr_out           = ((state == S_RD) || (state == S_WR)) ? reg_addr : 10'h000;
    assign drp_di_out             = di_q;
    assign drp_reconfig_done_out  = (state == S_DONE);
    assign drp_reconfig_error_out = err;
    assign drp_mode_am_out        = mode_am;
    assign sm_drp_ctrl_out        = state;

endmodule

// File: tb/tb_gtfwizard_0_gtwiz_rx_mode_drp_ctrl.sv
// Bench for the RX mode DRP sequencer: a DRP slave/arbiter model plus a write scoreboard.
module tb_gtfwizard_0_gtwiz_rx_mode_drp_ctrl;

    localparam logic [9:0]  R0_ADDR = 10'h07C;
    localparam logic [15:0] R0_MASK = 16'h00F0;
    localparam logic [15:0] R0_MM   = 16'h0050;
    localparam logic [15:0] R0_AM   = 16'h00A0;
    localparam logic [9:0]  R1_ADDR = 10'h07D;
    localparam logic [15:0] R1_MASK = 16'h0F00;
    localparam logic [15:0] R1_MM   = 16'h0300;
    localparam logic [15:0] R1_AM   = 16'h0C00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy_in = 1'b0;
    logic        switch_am = 1'b0;
    logic        done_out, err_out, mode_am_out, req_out, en_out, we_out;
    logic        gnt_in = 1'b0;
    logic [9:0]  addr_out;
    logic [15:0] di_out;
    logic [15:0] do_in = 16'h0000;
    logic        drdy_in = 1'b0;
    logic [2:0]  sm_out;

    int checks = 0;
    int errors = 0;

    // DRP slave / arbiter model controls
    int          gnt_delay = 0;
    bit          gnt_never = 1'b0;
    int          drdy_delay = 0;
    bit          block_rd1 = 1'b0;
    logic [15:0] rd0 = 16'h0000;
    logic [15:0] rd1 = 16'h0000;
    int          en_cnt = 0;
    int          req_cnt = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_do = 16'h0000;
    logic [25:0] exp_q[$];

    gtfwizard_0_gtwiz_rx_mode_drp_ctrl #(
        .P_DRP_TIMEOUT(255), .P_DONE_HOLD(8),
        .P_REG0_ADDR(R0_ADDR), .P_REG0_MASK(R0_MASK), .P_REG0_MM_VAL(R0_MM), .P_REG0_AM_VAL(R0_AM),
        .P_REG1_ADDR(R1_ADDR), .P_REG1_MASK(R1_MASK), .P_REG1_MM_VAL(R1_MM), .P_REG1_AM_VAL(R1_AM)
    ) dut (
        .drp_clk_in(clk),
        .drp_reset_in(rst),
        .drp_reconfig_rdy_in(rdy_in),
        .drp_switch_am_in(switch_am),
        .drp_reconfig_done_out(done_out),
        .drp_reconfig_error_out(err_out),
        .drp_mode_am_out(mode_am_out),
        .drp_req_out(req_out),
        .drp_gnt_in(gnt_in),
        .drp_en_out(en_out),
        .drp_we_out(we_out),
        .drp_addr_out(addr_out),
        .drp_di_out(di_out),
        .drp_do_in(do_in),
        .drp_rdy_in(drdy_in),
        .sm_drp_ctrl_out(sm_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rmw(input logic [15:0] rd, input logic [15:0] mask,
                                        input logic [15:0] val);
        return (rd & ~mask) | (val & mask);
    endfunction

    task automatic push_exp(input bit am, input bit both);
        exp_q.push_back({R0_ADDR, rmw(rd0, R0_MASK, am ? R0_AM : R0_MM)});
        if (both) exp_q.push_back({R1_ADDR, rmw(rd1, R1_MASK, am ? R1_AM : R1_MM)});
    endtask

    // Slave model: samples DUT strobes on the falling edge, answers one cycle later.
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (en_out === 1'b1) begin
                en_cnt++;
                checks++;
                if (gnt_in !== 1'b1) begin
                    errors++;
                    $display("FAIL en_without_gnt: en=%b gnt=%b required gnt=1", en_out, gnt_in);
                end
                if (we_out === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr=%h data=%h required no write", addr_out, di_out);
                    end else begin
                        e = exp_q.pop_front();
                        if ({addr_out, di_out} !== e) begin
                            errors++;
                            $display("FAIL write_data: addr=%h data=%h required addr=%h data=%h",
                                     addr_out, di_out, e[25:16], e[15:0]);
                        end
                    end
                end
            end
            drdy_in = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    drdy_in = 1'b1;
                    do_in   = pend_do;
                    pend    = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (en_out === 1'b1 && !(block_rd1 && we_out === 1'b0 && addr_out == R1_ADDR)) begin
                pend     = 1'b1;
                pend_cnt = drdy_delay;
                pend_do  = (we_out === 1'b1) ? 16'h0000 : ((addr_out == R1_ADDR) ? rd1 : rd0);
            end
            if (req_out === 1'b1) begin
                if (!gnt_never && req_cnt >= gnt_delay) gnt_in = 1'b1;
                else req_cnt++;
            end else begin
                gnt_in  = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Raise rdy_in (dropping it after pulse cycles if nonzero), wait for done, then measure its width.
    task automatic run_seq(input bit am, input int pulse, output int lat, output int done_len,
                           output bit to);
        @(negedge clk);
        switch_am = am;
        rdy_in    = 1'b1;
        lat       = 0;
        to        = 1'b0;
        done_len  = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == pulse) rdy_in = 1'b0;
            if (lat == 6) switch_am = ~am;
            if (done_out === 1'b1) break;
            if (lat >= 1000) begin
                to = 1'b1;
                break;
            end
        end
        if (!to) begin
            rdy_in = 1'b0;
            while (done_out === 1'b1 && done_len < 1000) begin
                done_len++;
                @(negedge clk);
            end
        end
        rdy_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({done_out, err_out, mode_am_out, req_out, en_out, we_out, addr_out, di_out, sm_out} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {done_out, err_out, mode_am_out, req_out, en_out, we_out, addr_out, di_out, sm_out});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (sm_out !== 3'd0 || req_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: sm=%0d req=%b required sm=0 req=0", sm_out, req_out);
        end
    endtask

    task automatic test_mm_path;
        int lat, dl;
        bit to;
        rd0 = 16'hABCD;
        rd1 = 16'h5A5A;
        push_exp(1'b0, 1'b1);
        run_seq(1'b0, 0, lat, dl, to);
        checks++;
        if (to || lat != 13) begin
            errors++;
            $display("FAIL mm_latency: got %0d (timeout=%b) required 13", lat, to);
        end
        checks++;
        if (err_out !== 1'b0 || mode_am_out !== 1'b0) begin
            errors++;
            $display("FAIL mm_flags: err=%b mode=%b required err=0 mode=0", err_out, mode_am_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mm_writes_left: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_am_path;
        int lat, dl;
        bit to;
        rd0 = 16'h1234;
        rd1 = 16'hFFFF;
        push_exp(1'b1, 1'b1);
        run_seq(1'b1, 0, lat, dl, to);
        checks++;
        if (to || lat != 13 || mode_am_out !== 1'b1 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL am_path: lat=%0d to=%b mode=%b err=%b required lat=13 mode=1 err=0",
                     lat, to, mode_am_out, err_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL am_writes_left: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_grant_delay;
        int lat, dl;
        bit to;
        gnt_delay = 40;
        rd0 = 16'h0F0F;
        rd1 = 16'h00FF;
        push_exp(1'b0, 1'b1);
        run_seq(1'b0, 0, lat, dl, to);
        gnt_delay = 0;
        checks++;
        if (to || lat != 53 || err_out !== 1'b0 || mode_am_out !== 1'b0) begin
            errors++;
            $display("FAIL grant_delay: lat=%0d to=%b err=%b mode=%b required lat=53 err=0 mode=0",
                     lat, to, err_out, mode_am_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grant_delay_writes_left: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_grant_timeout;
        int lat, dl, en0;
        bit to;
        gnt_never = 1'b1;
        en0 = en_cnt;
        run_seq(1'b1, 0, lat, dl, to);
        gnt_never = 1'b0;
        checks++;
        if (to || lat != 259) begin
            errors++;
            $display("FAIL gnt_timeout_latency: got %0d (timeout=%b) required 259", lat, to);
        end
        checks++;
        if (err_out !== 1'b1 || mode_am_out !== 1'b0 || dl != 8) begin
            errors++;
            $display("FAIL gnt_timeout_flags: err=%b mode=%b done_len=%0d required err=1 mode=0 done_len=8",
                     err_out, mode_am_out, dl);
        end
        checks++;
        if (en_cnt != en0) begin
            errors++;
            $display("FAIL gnt_timeout_en: got %0d strobes required 0", en_cnt - en0);
        end
    endtask

    task automatic test_drdy_timeout;
        int lat, dl;
        bit to;
        block_rd1 = 1'b1;
        rd0 = 16'hC3C3;
        push_exp(1'b1, 1'b0);
        run_seq(1'b1, 0, lat, dl, to);
        block_rd1 = 1'b0;
        checks++;
        if (to || lat != 265) begin
            errors++;
            $display("FAIL drdy_timeout_latency: got %0d (timeout=%b) required 265", lat, to);
        end
        checks++;
        if (err_out !== 1'b1 || mode_am_out !== 1'b0 || req_out !== 1'b0 || dl < 8) begin
            errors++;
            $display("FAIL drdy_timeout_flags: err=%b mode=%b req=%b done_len=%0d required err=1 mode=0 req=0 done_len>=8",
                     err_out, mode_am_out, req_out, dl);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drdy_timeout_writes_left: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int lat, dl;
        bit to;
        rd0 = 16'hFFFF;
        rd1 = 16'h0000;
        push_exp(1'b0, 1'b1);
        run_seq(1'b0, 2, lat, dl, to);
        checks++;
        if (to || lat != 13 || dl != 8 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL pulse_seq: lat=%0d to=%b done_len=%0d err=%b required lat=13 done_len=8 err=0",
                     lat, to, dl, err_out);
        end
        checks++;
        if (sm_out !== 3'd0) begin
            errors++;
            $display("FAIL pulse_idle: sm=%0d required 0", sm_out);
        end
        rd0 = 16'h8001;
        rd1 = 16'h7FFE;
        push_exp(1'b1, 1'b1);
        run_seq(1'b1, 0, lat, dl, to);
        checks++;
        if (to || lat != 13 || mode_am_out !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL second_seq: lat=%0d to=%b mode=%b left=%0d required lat=13 mode=1 left=0",
                     lat, to, mode_am_out, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_seq;
        int n, act, lat, dl;
        bit to;
        drdy_delay = 3;
        rd0 = 16'h1111;
        push_exp(1'b0, 1'b0);
        @(negedge clk);
        switch_am = 1'b0;
        rdy_in    = 1'b1;
        n = 0;
        while (sm_out !== 3'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sm_out !== 3'd5) begin
            errors++;
            $display("FAIL reach_wait_wr: sm=%0d required 5", sm_out);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({req_out, en_out, we_out, done_out, addr_out, di_out, sm_out} !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0",
                     {req_out, en_out, we_out, done_out, addr_out, di_out, sm_out});
        end
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_out !== 1'b0 || en_out !== 1'b0 || sm_out !== 3'd0) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL no_restart: got %0d active cycles required 0", act);
        end
        rdy_in = 1'b0;
        drdy_delay = 0;
        repeat (5) @(negedge clk);
        rd0 = 16'h0000;
        rd1 = 16'h0000;
        push_exp(1'b0, 1'b1);
        run_seq(1'b0, 0, lat, dl, to);
        checks++;
        if (to || lat != 13 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL recover_after_reset: lat=%0d to=%b left=%0d required lat=13 left=0",
                     lat, to, exp_q.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mm_path();
        test_am_path();
        test_grant_delay();
        test_grant_timeout();
        test_drdy_timeout();
        test_back_to_back();
        test_reset_mid_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gtfwizard_0_gtwiz_rx_mode_drp_ctrl.md
Name: gtfwizard_0_gtwiz_rx_mode_drp_ctrl

Overview:
- DRP sequencer serving the RX buffer-bypass controller's reconfiguration handshake.
- On each new reconfiguration request it arbitrates for the shared GTF DRP port and read-modify-writes two RX phase-alignment registers to their manual-mode (MM) or auto-mode (AM) values.
- It then returns a held done level that the bypass controller synchronizes and edge-detects.
- Sits between the bypass FSM and the GTF channel DRP, beside the user DRP master, behind an external DRP arbiter.

Parameters:
P_DRP_TIMEOUT, 255, cycles to wait for drdy (and for gnt) before aborting; 8-bit range 2..255
P_DONE_HOLD, 8, minimum cycles drp_reconfig_done_out stays high; 1..255
P_REG0_ADDR, 10'h000, DRP address of register 0
P_REG0_MASK, 16'h0000, bits of register 0 owned by this block
P_REG0_MM_VAL, 16'h0000, register 0 value under mask for MM
P_REG0_AM_VAL, 16'h0000, register 0 value under mask for AM
P_REG1_ADDR / P_REG1_MASK / P_REG1_MM_VAL / P_REG1_AM_VAL, same defaults, register 1 equivalents

Ports:
- drp_clk_in  in  1  DRP clock; sole clock.
- drp_reset_in  in  1  Asynchronous active-high reset.
- drp_reconfig_rdy_in  in  1  Request level from the bypass FSM; asynchronous.
- drp_switch_am_in  in  1  1 = apply AM values, 0 = apply MM values; asynchronous.
- drp_reconfig_done_out  out  1  Completion level back to the bypass FSM.
- drp_reconfig_error_out  out  1  Sticky timeout flag for the last sequence.
- drp_mode_am_out  out  1  Mode last written successfully.
- drp_req_out  out  1  DRP ownership request to the arbiter.
- drp_gnt_in  in  1  DRP ownership grant.
- drp_en_out  out  1  DRP enable, one-cycle strobe.
- drp_we_out  out  1  DRP write enable, qualified by drp_en_out.
- drp_addr_out  out  10  DRP address.
- drp_di_out  out  16  DRP write data.
- drp_do_in  in  16  DRP read data, valid with drp_rdy_in.
- drp_rdy_in  in  1  DRP transaction complete.
- sm_drp_ctrl_out  out  3  FSM state, debug.

Behaviour:
- Synchronization: rdy_in and switch_am_in each pass through a 3-FF synchronizer (rdy_s, am_s). Start = rising edge of rdy_s in IDLE. A rdy_s level already high when leaving reset does not start a sequence until it falls and rises again.
- Reset values: all outputs 0, addr/di 0, FSM in IDLE, reg index 0, counters 0. Asserting reset mid-sequence aborts immediately: en/req drop asynchronously, and a late drdy after reset is ignored.
- States (encoding 0-6):
  - IDLE(0): on start, latch am_s into mode_sel, clear error_out, index := 0 -> REQ.
  - REQ(1): req_out = 1. gnt_in -> RD. Timeout -> DONE with error.
  - RD(2): en = 1, we = 0, addr = REGn_ADDR for one cycle -> WAIT_RD.
  - WAIT_RD(3): on drdy, latch di = (do & ~MASK) | (VAL & MASK), where VAL = mode_sel ? AM_VAL : MM_VAL -> WR.
  - WR(4): en = 1, we = 1, addr = REGn_ADDR for one cycle -> WAIT_WR.
  - WAIT_WR(5): on drdy, if index == 1 -> DONE with mode_am_out := mode_sel; else index := 1 -> RD.
  - DONE(6): req_out = 0, done_out = 1. Stay until hold count >= P_DONE_HOLD and rdy_s == 0, then done_out = 0 -> IDLE.
- req_out is high from REQ through WAIT_WR inclusive. en_out is only ever asserted while gnt_in is high.
- Timeout: an 8-bit counter clears on entry to REQ/WAIT_RD/WAIT_WR and increments each cycle without gnt/drdy. At count == P_DRP_TIMEOUT: error_out := 1 -> DONE. mode_am_out is unchanged on error.
- A gnt_in deassertion while an access is outstanding is ignored; the transaction completes.
- The DONE hold counter reuses the timeout counter (cleared on DONE entry, saturating).
- drdy outside WAIT_RD/WAIT_WR is ignored.
- Changes to switch_am_in after start have no effect on the running sequence.
- If rdy_in falls mid-sequence, the sequence still completes and DONE holds for P_DONE_HOLD cycles.
- MASK == 0 for a register still performs the read and write-back (value unchanged).
- Latency with zero-wait gnt/drdy: 3 sync + 1 edge + 1 REQ + 2×(1 RD + 1 WAIT + 1 WR + 1 WAIT) = 13 cycles from rdy_in rise to done_out rise.

Test Plan:
- MM path: REG0_ADDR = 10'h07C, MASK = 16'h00F0, MM_VAL = 16'h0050, do = 16'hABCD, immediate gnt/drdy, switch_am = 0 -> writes 16'hAB5D to 07C and the REG1 equivalent; done_out high 13 cycles after rdy rise; mode_am_out = 0; error_out = 0.
- AM path: same registers, switch_am = 1, AM_VAL = 16'h00A0, do = 16'h1234 -> write 16'h12A4; mode_am_out = 1.
- Grant delay: gnt_in withheld 40 cycles -> no drp_en_out before gnt; sequence completes normally. Gnt withheld > 255 cycles -> error_out = 1, done_out = 1, no en pulse, mode_am_out unchanged.
- drdy timeout on the REG1 read -> error_out = 1 after exactly 255 waiting cycles; done held ≥ 8 cycles; req_out released.
- rdy_in pulsed for 2 cycles only -> sequence completes; done_out high exactly P_DONE_HOLD = 8 cycles, then IDLE. A second rdy rise starts a new sequence that clears error_out.
- Reset asserted during WAIT_WR, followed by a late drdy -> all outputs 0 asynchronously, FSM in IDLE; the drdy causes no activity; rdy_in held high across reset causes no restart.
